serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have one clock and an asynchronous active-low reset: port clk, port rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_valid  input  1  request carries operands a, b, cin.
REQ-006 start_ready  output  1  controller can accept a request.
REQ-007 a  input  WIDTH  operand A, sampled only on the accept edge.
REQ-008 b  input  WIDTH  operand B, sampled only on the accept edge.
REQ-009 cin  input  1  carry-in, sampled only on the accept edge.
REQ-010 busy  output  1  high while an addition is in progress (RUN state).
REQ-011 result_valid  output  1  sum and cout hold a completed result.
REQ-012 result_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result bits, a+b+cin modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: start_ready=1, busy=0, result_valid=0.
REQ-017 Accept = start_valid && start_ready at a rising clk edge: load a, b into operand shift registers, load cin into the carry flop, clear the bit counter, go to RUN.
REQ-018 start_valid while start_ready=0 SHALL be ignored; operands SHALL not be resampled.
REQ-019 RUN: start_ready=0, busy=1. Each cycle, one full-add of the operand LSBs and the carry flop; the sum bit shifts into the sum register MSB (shift right); the carry flop updates; the operand registers shift right; the counter increments.
REQ-020 RUN SHALL last exactly WIDTH cycles. The edge on which the counter reaches WIDTH SHALL move the FSM to DONE and load cout from the final carry.
REQ-021 Latency: result_valid SHALL rise exactly WIDTH clk edges after the accept edge.
REQ-022 DONE: result_valid=1, busy=0, start_ready=0. sum and cout SHALL hold stable until result_ready=1.
REQ-023 DONE with result_ready=1 at an edge SHALL return to IDLE. result_valid falls on that edge. Consecutive accepts are therefore at least WIDTH+2 edges apart.
REQ-024 result_ready outside DONE SHALL have no effect.
REQ-025 In IDLE, sum and cout SHALL retain the last completed result until the next accept.
REQ-026 Counter width SHALL be $clog2(WIDTH+1) bits. No counter wrap is reachable.
REQ-027 WIDTH=1 SHALL work: one RUN cycle, then DONE.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force IDLE and clear to 0: sum, cout, carry flop, counter, operand registers and result_valid. busy SHALL be 0; start_ready SHALL be 1 once rst_n is high.
REQ-029 Reset during RUN or DONE SHALL abandon the operation; no result_valid SHALL follow.

Structure
REQ-030 Package serial_adder_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-031 One sub-module, full_adder_cell (inputs a, b, cin; outputs s, co), SHALL be built structurally from gate primitives as two half-adder XOR/AND pairs plus an OR. The controller SHALL instantiate it once.
REQ-032 All sequential logic SHALL live in serial_adder_ctrl; full_adder_cell SHALL be purely combinational.

Verification (WIDTH=8 unless stated)
REQ-033 a=3, b=5, cin=0 -> result_valid 8 edges after accept; sum=8, cout=0.
REQ-034 a=255, b=1, cin=0 -> sum=0, cout=1; a=0, b=0, cin=1 -> sum=1, cout=0.
REQ-035 result_ready held low 5 cycles in DONE -> result_valid, sum and cout stable throughout; first edge with result_ready=1 -> IDLE, start_ready=1.
REQ-036 start_valid pulsed with a=7 during RUN of 3+5 -> ignored; result still 8; busy high for exactly 8 cycles.
REQ-037 rst_n low for 1 cycle at RUN cycle 4 -> outputs 0 immediately; start_ready=1 after release; no result_valid within 20 cycles.
REQ-038 WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1 one edge after accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder XOR/AND pairs and an OR.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p, g1, g2;

  xor u_x1 (p,  a, b);
  and u_a1 (g1, a, b);
  xor u_x2 (s,  p, cin);
  and u_a2 (g2, p, cin);
  or  u_o1 (co, g1, g2);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-add per RUN cycle, LSB first, result held in DONE
// until the consumer takes it.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_nx;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  full_adder_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign accept   = start_valid && (state_q == IDLE);
  assign last_bit = (cnt_q == LAST);

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at sum[0].
  generate
    if (WIDTH == 1) begin : g_sum1
      assign sum_nx = fa_s;
    end else begin : g_sumn
      assign sum_nx = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid)  state_d = RUN;
      RUN:     if (last_bit)     state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state_q == IDLE);
    busy         = (state_q == RUN);
    result_valid = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = sum_nx;
      carry_d = fa_co;
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) cout_d = fa_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start_valid = 1'b0, start_ready, cin = 1'b0, busy, result_valid;
  logic       result_ready = 1'b0, cout;
  logic [7:0] a = '0, b = '0, sum;

  logic       start_valid1 = 1'b0, start_ready1, cin1 = 1'b0, busy1, result_valid1;
  logic       result_ready1 = 1'b0, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid1), .start_ready(start_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .result_valid(result_valid1), .result_ready(result_ready1),
    .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept one request, bound the wait for the result, check it and release it.
  task automatic do_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int lat;
    a = va; b = vb; cin = vc; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, "_rv_fall"}, result_valid, 0);
  endtask

  initial begin
    int busy_cnt;
    int rv_seen;

    #2;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 3+5: exact latency, hold in DONE, then release
    a = 8'd3; b = 8'd5; cin = 1'b0; start_valid = 1'b1;
    result_ready = 1'b1;  // no effect outside DONE
    tick();
    start_valid = 1'b0;
    result_ready = 1'b0;
    chk("t1_busy_after_accept", busy, 1);
    chk("t1_ready_low", start_ready, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t1_rv_edge%0d", k), result_valid, (k == 8) ? 1 : 0);
    end
    chk("t1_sum", sum, 8);
    chk("t1_cout", cout, 0);
    chk("t1_busy_done", busy, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_hold_rv", result_valid, 1);
      chk("t1_hold_sum", sum, 8);
      chk("t1_hold_cout", cout, 0);
      chk("t1_hold_ready", start_ready, 0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("t1_rv_fall", result_valid, 0);
    chk("t1_ready_back", start_ready, 1);
    tick();
    chk("t1_idle_sum_kept", sum, 8);

    do_add("t2", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1);
    chk("t2_idle_cout_kept", cout, 1);
    do_add("t3", 8'd0, 8'd0, 1'b1, 8'd1, 1'b0);
    do_add("t4", 8'd200, 8'd100, 1'b1, 8'd45, 1'b1);

    // start_valid during RUN must be ignored
    a = 8'd3; b = 8'd5; cin = 1'b0; start_valid = 1'b1;
    tick();
    busy_cnt = 0;
    a = 8'd7;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) start_valid = 1'b0;
      if (busy) busy_cnt++;
      if (!result_valid) tick();
    end
    chk("t5_busy_cycles", busy_cnt, 8);
    chk("t5_rv", result_valid, 1);
    chk("t5_sum", sum, 8);
    chk("t5_cout", cout, 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // reset mid-RUN
    a = 8'd3; b = 8'd5; cin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 0);
    chk("t6_sum_rst", sum, 0);
    chk("t6_cout_rst", cout, 0);
    chk("t6_rv_rst", result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_after", start_ready, 1);
    rv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (result_valid || busy) rv_seen++;
    end
    chk("t6_no_result", rv_seen, 0);

    // WIDTH=1
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start_valid1 = 1'b1;
    tick();
    start_valid1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_rv_early", result_valid1, 0);
    tick();
    chk("w1_rv", result_valid1, 1);
    chk("w1_sum", sum1, 1);
    chk("w1_cout", cout1, 1);
    result_ready1 = 1'b1;
    tick();
    result_ready1 = 1'b0;
    chk("w1_idle", start_ready1, 1);
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; start_valid1 = 1'b1;
    tick();
    start_valid1 = 1'b0;
    tick();
    chk("w1b_rv", result_valid1, 1);
    chk("w1b_sum", sum1, 1);
    chk("w1b_cout", cout1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
